// File: rtl/mmcm_reset_seq_if.sv
// Signal bundle between the MMCM reset sequencer and the clocking wrapper
// that owns the MMCM primitive. The sequencer is the master: it receives
// LOCKED and drives the MMCM reset plus the status outputs.
interface mmcm_reset_seq_if;
  logic       locked;
  logic       mmcm_rst;
  logic       clocks_ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_lost_count;

  modport master (
    input  locked,
    output mmcm_rst,
    output clocks_ready,
    output fail,
    output retry_count,
    output lock_lost_count
  );

  modport slave (
    output locked,
    input  mmcm_rst,
    input  clocks_ready,
    input  fail,
    input  retry_count,
    input  lock_lost_count
  );
endinterface

// File: rtl/mmcm_reset_seq.sv
// MMCM reset sequencer. Runs from the free-running oscillator clock, pulses
// the MMCM reset, waits for LOCKED to be stable for a programmable time and
// only then reports clocks_ready. It retries on lock timeout, re-resets on
// lock loss, and parks in a sticky FAIL state once the retry budget is spent.
// Every output is a register, so nothing downstream sees a combinational
// path from the asynchronous LOCKED input.
module mmcm_reset_seq #(
  parameter int unsigned RST_HOLD_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned LOCK_STABLE     = 1024,
  parameter int unsigned MAX_RETRIES     = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  mmcm_reset_seq_if.master bus
);

  // A single shared counter covers the reset hold, the lock timeout and the
  // stability window, so it is sized for the largest of the three.
  localparam int unsigned MAX_AB = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int          CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [4:0]       RETRY_LIMIT  = 5'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_READY     = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic [4:0]       retry_plus1;

  assign locked_s    = sync_q[1];
  assign retry_plus1 = {1'b0, bus.retry_count} + 5'd1;

  // Bring the MMCM LOCKED flag into the clk_in domain before any decision uses it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.locked};
    end
  end

  // Sequencer FSM; outputs are updated on the same edge as the state change.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state               <= S_RESET;
      cnt                 <= '0;
      bus.mmcm_rst        <= 1'b1;
      bus.clocks_ready    <= 1'b0;
      bus.fail            <= 1'b0;
      bus.retry_count     <= 4'd0;
      bus.lock_lost_count <= 8'd0;
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == RST_LAST) begin
            state        <= S_WAIT_LOCK;
            cnt          <= '0;
            bus.mmcm_rst <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt          <= '0;
            bus.mmcm_rst <= 1'b1;
            if (bus.retry_count != 4'hF) begin
              bus.retry_count <= bus.retry_count + 4'd1;
            end
            if (retry_plus1 >= RETRY_LIMIT) begin
              state    <= S_FAIL;
              bus.fail <= 1'b1;
            end else begin
              state <= S_RESET;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state            <= S_READY;
            cnt              <= '0;
            bus.clocks_ready <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        S_READY: begin
          if (!locked_s) begin
            state            <= S_RESET;
            cnt              <= '0;
            bus.mmcm_rst     <= 1'b1;
            bus.clocks_ready <= 1'b0;
            if (bus.lock_lost_count != 8'hFF) begin
              bus.lock_lost_count <= bus.lock_lost_count + 8'd1;
            end
          end
        end

        S_FAIL: begin
          bus.mmcm_rst     <= 1'b1;
          bus.clocks_ready <= 1'b0;
          bus.fail         <= 1'b1;
        end

        default: begin
          state            <= S_RESET;
          cnt              <= '0;
          bus.mmcm_rst     <= 1'b1;
          bus.clocks_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
